// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- oversampling UART receiver (8N1, or 8E1 with parity compiled in).
//
// Consumes a one-cycle oversample tick from the baud generator and the raw
// serial line. It recovers frames and presents each received word with
// one-cycle status strobes. Everything runs in the i_Clk domain.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : an even-parity bit follows the data bits, and o_Parity_Err is live.
//   undefined : no parity bit, STOP follows DATA directly, and o_Parity_Err = 0.
//
// Ports:
//   i_Clk          system clock, rising edge
//   i_Rst          synchronous, active-high reset
//   i_Tick         oversample enable, OVERSAMPLE pulses per bit period
//   i_Rx           asynchronous serial line, idles high
//   o_Data         last received data word (LSB received first)
//   o_Valid        one-cycle strobe: o_Data holds a good frame
//   o_Frame_Err    one-cycle strobe: stop bit sampled low
//   o_Parity_Err   one-cycle strobe: parity mismatch
//   o_Busy         high whenever the receiver is not idle
//
// Output protocol: there is no ready/backpressure. o_Valid, o_Frame_Err and
// o_Parity_Err are registered, last exactly one cycle, and rise on the edge
// that also updates o_Data. o_Data then holds until the next frame completes.
// The consumer must capture o_Data within one frame time.
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16   // even, >= 4
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_Tick,
  input  logic                 i_Rx,
  output logic [DATA_BITS-1:0] o_Data,
  output logic                 o_Valid,
  output logic                 o_Frame_Err,
  output logic                 o_Parity_Err,
  output logic                 o_Busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_meta_q, rx_s_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
  logic                 par_bad;

  // Even parity: the XOR of the data bits and the parity bit must be 0.
  assign par_bad = ^{shift_q, par_q};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    armed_d = armed_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        // armed is set only after the line has been seen high. After a frame
        // error, a line held low (break) therefore cannot start a new frame.
        if (i_Tick) begin
          if (rx_s_q) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = S_START;
            cnt_d   = '0;
            armed_d = 1'b0;
          end
        end
      end

      S_START: begin
        if (i_Tick) begin
          if (cnt_q == CNT_MID) begin
            // Mid start bit: a high line means the edge was a glitch.
            cnt_d = '0;
            if (!rx_s_q) begin
              state_d = S_DATA;
              idx_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_DATA: begin
        if (i_Tick) begin
          if (cnt_q == CNT_END) begin
            // Right shift, so the first (LSB) bit ends up at bit 0.
            cnt_d                  = '0;
            shift_d                = shift_q >> 1;
            shift_d[DATA_BITS-1]   = rx_s_q;
            idx_d                  = idx_q + IW'(1);
            if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (i_Tick) begin
          if (cnt_q == CNT_END) begin
            cnt_d   = '0;
            par_d   = rx_s_q;
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
`endif

      S_STOP: begin
        if (i_Tick) begin
          if (cnt_q == CNT_END) begin
            // Returning to IDLE at mid stop bit leaves half a bit of margin
            // to catch a start bit that follows immediately.
            cnt_d   = '0;
            state_d = S_IDLE;
            data_d  = shift_q;
            ferr_d  = ~rx_s_q;
`ifdef UART_RX_PARITY_EN
            perr_d  = par_bad;
            valid_d = rx_s_q & ~par_bad;
`else
            valid_d = rx_s_q;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      armed_q   <= 1'b0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      armed_q   <= armed_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      rx_meta_q <= i_Rx;
      rx_s_q    <= rx_meta_q;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign o_Data      = data_q;
  assign o_Valid     = valid_q;
  assign o_Frame_Err = ferr_q;
  assign o_Busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign o_Parity_Err = perr_q;
`else
  assign o_Parity_Err = 1'b0;
`endif

endmodule
